dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single data-memory block-RAM port between two requesters: the CPU memory stage (port 0) and a bulk-transfer DMA/loader engine (port 1).
- Requester 0 has priority, but a starvation counter guarantees that requester 1 makes forward progress.
- Tracks the one-cycle BRAM read latency and steers each read result back to the requester that issued it.
- Sits between the core/mem_control write-enable decode and the dmem block RAM.

Parameters:
- XLEN, 32, data width.
- ADDR_W, 14, word-address width of the BRAM port.
- STARVE_MAX, 4, number of consecutive cycles requester 1 may be denied before it is forced to win.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 (CPU) access request.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  XLEN  requester 0 write data.
- wea0  in  4  requester 0 byte write enables; 0 means read.
- gnt0  out  1  requester 0 accepted this cycle.
- rvalid0  out  1  requester 0 read data valid.
- rdata0  out  XLEN  requester 0 read data.
- req1, addr1, wdata1, wea1, gnt1, rvalid1, rdata1: same as port 0, for requester 1 (DMA).
- mem_en  out  1  BRAM enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_din  out  XLEN  BRAM write data.
- mem_wea  out  4  BRAM byte write enables.
- mem_dout  in  XLEN  BRAM read data, valid one cycle after an enabled read.
- starved  out  1  force-priority state is active for requester 1 (debug).

Behaviour:
- Reset (asynchronous, active-high): all registered state clears immediately.
  - gnt0/1=0, rvalid0/1=0, starve_cnt=0, starved=0, rd_pending=0, rd_owner=0.
  - mem_en=0 and mem_wea=0 while rst is high.
  - rdata0/1 are don't-care but driven from mem_dout.
- Grant (combinational in the request cycle):
  - Normal: req0 wins; otherwise req1 wins if asserted.
  - When starved=1 and req1 is asserted, req1 wins over req0.
  - At most one of gnt0/gnt1 is high; gntN=0 whenever reqN=0.
- Memory drive: while a grant is given, mem_en=1 and mem_addr/mem_din/mem_wea come from the winner. With no grant, mem_en=0 and mem_wea=0.
- Requester rules:
  - A denied requester holds req and its addr/data/wea stable until it sees gnt.
  - An access completes in the cycle it is granted (1 transaction per cycle, full throughput).
- Read tracking:
  - On a granted read (wea==0), rd_pending<=1 and rd_owner<=winner at the clock edge.
  - In the next cycle rvalidN=1 for N==rd_owner, and rdataN=mem_dout. The other rvalid stays 0.
  - Writes never generate rvalid.
  - Back-to-back reads from alternating owners each return in order, one cycle later.
- Starvation state machine, two states: NORMAL(starved=0) and FORCE(starved=1).
  - NORMAL: each cycle with req1=1 and gnt1=0 increments starve_cnt. Any gnt1, or req1=0, clears it.
  - When starve_cnt reaches STARVE_MAX-1 and req1 is denied again, go to FORCE.
  - FORCE: the next cycle with req1=1 grants port 1, returns to NORMAL and clears the counter.
  - FORCE: if req1 drops, return to NORMAL with no grant.
  - starve_cnt width is $clog2(STARVE_MAX)+1 and saturates; it never wraps.
- Simultaneous events:
  - A write and a read to the same address on the same cycle cannot occur (single port).
  - Read-after-write to the same address on consecutive grants returns the new data (BRAM write-first). The verifier's model uses write-first.
- Reset mid-operation: a pending read is dropped (no rvalid after reset deasserts), and the FSM returns to NORMAL.

Decomposition:
- Shared package/defines: XLEN, the port-id constants (PORT_CPU=0, PORT_DMA=1), and the FSM state encodings (ARB_NORMAL, ARB_FORCE).
- One sub-module is natural: arb_starve_ctr, which holds the counter plus the NORMAL/FORCE FSM. It takes req1 and gnt1 and outputs starved.
- The grant mux and read tracker stay in the top level.

Test Plan:
- Reset then idle: after rst is released with no requests, mem_en=0, gnt0=gnt1=0, rvalid=0 for 10 cycles.
- Single CPU write then read:
  - Write addr0=0x010, wdata0=0xDEADBEEF, wea0=0xF, giving gnt0=1 with mem_wea=0xF.
  - Read the same address: gnt0=1, then on the next cycle rvalid0=1 and rdata0=0xDEADBEEF, with rvalid1=0.
- Contention: req0 and req1 both held high for reads, STARVE_MAX=4.
  - gnt0 for cycles 0-3.
  - starved=1 after the 4th denial; gnt1 on cycle 4; then gnt0 resumes.
  - rvalid owners follow the grant sequence with a 1-cycle delay.
- FORCE abort: drive req1 into FORCE, then drop req1. starved returns to 0 with no gnt1, and req0 keeps being granted.
- Alternating reads: port0 reads 0x001 and port1 reads 0x002 in consecutive cycles. rvalid0 carries mem[1], then rvalid1 carries mem[2], with no overlap.
- Reset mid-read: assert rst in the cycle after a granted read. No rvalid follows, and starve_cnt=0 after reset is released.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared constants and types for the data-memory arbiter slice.
//   XLEN / ADDR_W / STARVE_MAX : default widths and starvation limit
//   PORT_CPU / PORT_DMA        : requester ids used by the read tracker
//   arb_state_t                : NORMAL / FORCE starvation FSM encodings
package dmem_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int ADDR_W     = 14;
  localparam int STARVE_MAX = 4;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DMA = 1'b1;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  // Counter width able to hold 0..STARVE_MAX with headroom for saturation.
  function automatic int starve_cnt_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// arb_starve_ctr
// Starvation guard for the DMA requester. Counts consecutive cycles in which
// requester 1 asks but is denied; once the limit is hit, the FSM enters FORCE
// so that requester 1 wins the next arbitration it participates in.
//   clk, rst : clock, asynchronous active-high reset
//   req1     : requester 1 request
//   gnt1     : requester 1 grant (from the top-level grant mux)
//   starved  : FORCE state active, requester 1 takes priority
module arb_starve_ctr #(
  parameter int STARVE_MAX = dmem_arbiter_pkg::STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic gnt1,
  output logic starved
);

  import dmem_arbiter_pkg::arb_state_t;
  import dmem_arbiter_pkg::ARB_NORMAL;
  import dmem_arbiter_pkg::ARB_FORCE;
  import dmem_arbiter_pkg::starve_cnt_width;

  localparam int CNT_W = starve_cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  // State and counter registers; reset drops straight back to NORMAL with an
  // empty counter so a half-built starvation history never survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // In NORMAL, each denial while requesting bumps the counter and the denial
  // seen with the counter already at the last slot tips us into FORCE. FORCE
  // lasts exactly one cycle: either requester 1 is granted (the grant mux
  // guarantees it while starved is high) or it has withdrawn, and both cases
  // restart the history from zero.
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    if (state == ARB_NORMAL) begin
      if (req1 && !gnt1) begin
        if (starve_cnt >= CNT_LAST) begin
          state_nxt = ARB_FORCE;
        end else if (starve_cnt != CNT_SAT) begin
          starve_cnt_nxt = starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt_nxt = '0;
      end
    end else begin
      state_nxt      = ARB_NORMAL;
      starve_cnt_nxt = '0;
    end
  end

  assign starved = (state == ARB_FORCE);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single dmem BRAM port between the CPU memory stage (port 0) and
// the DMA/loader engine (port 1). Port 0 normally wins; a starvation guard
// forces a port 1 win after STARVE_MAX consecutive denials. Read results come
// back one cycle after the grant and are flagged to the issuing requester.
//   clk, rst                  : clock, asynchronous active-high reset
//   reqN/addrN/wdataN/weaN    : requester N access (wea==0 is a read)
//   gntN                      : requester N accepted this cycle
//   rvalidN/rdataN            : requester N read return
//   mem_en/addr/din/wea       : BRAM port drive
//   mem_dout                  : BRAM read data, one cycle after a read
//   starved                   : FORCE priority active for requester 1
module dmem_arbiter #(
  parameter int XLEN       = dmem_arbiter_pkg::XLEN,
  parameter int ADDR_W     = dmem_arbiter_pkg::ADDR_W,
  parameter int STARVE_MAX = dmem_arbiter_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [XLEN-1:0]   wdata0,
  input  logic [3:0]        wea0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [XLEN-1:0]   rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [XLEN-1:0]   wdata1,
  input  logic [3:0]        wea1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [XLEN-1:0]   rdata1,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_din,
  output logic [3:0]        mem_wea,
  input  logic [XLEN-1:0]   mem_dout,
  output logic              starved
);

  import dmem_arbiter_pkg::port_id_t;
  import dmem_arbiter_pkg::PORT_CPU;
  import dmem_arbiter_pkg::PORT_DMA;

  logic     any_gnt;
  logic     rd_grant;
  port_id_t win_id;
  logic [3:0] win_wea;
  logic     rd_pending;
  port_id_t rd_owner;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .req1    (req1),
    .gnt1    (gnt1),
    .starved (starved)
  );

  // Grant and BRAM drive. Port 1 wins when it asks and either port 0 is idle
  // or the starvation guard is in FORCE. Grants are held off while rst is
  // high so the BRAM never sees an enable during reset.
  always_comb begin
    gnt1     = !rst && req1 && (starved || !req0);
    gnt0     = !rst && req0 && !gnt1;
    any_gnt  = gnt0 || gnt1;
    win_id   = gnt1 ? PORT_DMA : PORT_CPU;
    win_wea  = gnt1 ? wea1 : wea0;
    rd_grant = any_gnt && (win_wea == 4'b0000);
    mem_en   = any_gnt;
    mem_addr = gnt1 ? addr1 : addr0;
    mem_din  = gnt1 ? wdata1 : wdata0;
    mem_wea  = any_gnt ? win_wea : 4'b0000;
  end

  // Read tracker: remember that the BRAM will present data next cycle and who
  // asked for it. Only one read can be outstanding since latency is one cycle
  // and the owner is overwritten on every granted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_owner   <= PORT_CPU;
    end else begin
      rd_pending <= rd_grant;
      if (rd_grant) begin
        rd_owner <= win_id;
      end
    end
  end

  assign rvalid0 = rd_pending && (rd_owner == PORT_CPU);
  assign rvalid1 = rd_pending && (rd_owner == PORT_DMA);
  assign rdata0  = mem_dout;
  assign rdata1  = mem_dout;

endmodule
